// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Fetch-stage program-counter generator. Next-PC selection by
//            priority (trap > jump > hold > RAS return > call > sequential),
//            16/32-bit step, and a circular return-address stack driven by
//            predecode call/ret hints.
// Ports    : clk, rst_n          - clock, async active-low reset
//            trap_flag_i/addr_i  - trap redirect (also flushes the RAS)
//            jump_flag_i/addr_i  - branch/jump redirect
//            hold_flag_i         - pipeline hold level
//            rvc_i               - instruction at pc_o is 16-bit
//            pred_call_i/ret_i   - predecode hints for the instruction at pc_o
//            pred_target_i       - predicted call target
//            pc_o, pc_valid_o    - fetch address and its valid flag
//            ras_empty_o/full_o  - RAS occupancy flags (registered)
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR     = 32'h0,
    parameter int unsigned       RAS_DEPTH      = 4,
    parameter logic [2:0]        PAUSE_PC_LEVEL = 3'd1,
    parameter int unsigned       C_EXT          = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic [2:0]        hold_flag_i,
    input  logic              rvc_i,
    input  logic              pred_call_i,
    input  logic              pred_ret_i,
    input  logic [ADDR_W-1:0] pred_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              ras_empty_o,
    output logic              ras_full_o
);

    localparam int unsigned       c_ptr_w    = $clog2(RAS_DEPTH);
    localparam int unsigned       c_cnt_w    = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(RAS_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    // Redirect targets must land on an instruction boundary: halfword
    // aligned when compressed instructions exist, word aligned otherwise.
    localparam logic [ADDR_W-1:0] c_align_mask = (C_EXT != 0) ? ~ADDR_W'(1) : ~ADDR_W'(3);

    logic [ADDR_W-1:0]  r_pc;
    logic               r_valid;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] r_top;
    logic               r_empty;
    logic               r_full;
    logic [ADDR_W-1:0]  r_ras [RAS_DEPTH];

    logic [ADDR_W-1:0]  w_step;
    logic [ADDR_W-1:0]  w_pc_seq;
    logic [c_ptr_w-1:0] w_top_inc;
    logic               w_hold;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_ptr_w-1:0] w_top_nxt;
    logic               w_ras_we;
    logic [c_ptr_w-1:0] w_ras_widx;
    logic [ADDR_W-1:0]  w_ras_wdata;

    assign w_step    = ((C_EXT != 0) && rvc_i) ? ADDR_W'(2) : ADDR_W'(4);
    assign w_pc_seq  = r_pc + w_step;
    // RAS_DEPTH is a power of two, so the pointer wraps on its own.
    assign w_top_inc = r_top + c_ptr_one;
    assign w_hold    = (hold_flag_i >= PAUSE_PC_LEVEL);

    always_comb begin
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_count;
        w_top_nxt   = r_top;
        w_ras_we    = 1'b0;
        w_ras_widx  = r_top;
        w_ras_wdata = w_pc_seq;
        if (r_valid) begin
            if (trap_flag_i) begin
                w_pc_nxt  = trap_addr_i & c_align_mask;
                w_cnt_nxt = '0;
            end else if (jump_flag_i) begin
                w_pc_nxt = jump_addr_i & c_align_mask;
            end else if (w_hold) begin
                w_pc_nxt = r_pc;
            end else if (pred_ret_i && !r_empty) begin
                w_pc_nxt = r_ras[r_top];
                if (pred_call_i) begin
                    // Tail call through a return: replace the top in place.
                    w_ras_we = 1'b1;
                end else begin
                    w_top_nxt = r_top - c_ptr_one;
                    w_cnt_nxt = r_count - c_cnt_one;
                end
            end else if (pred_call_i) begin
                // When full, the slot after top is the oldest entry, so the
                // push overwrites it and the count saturates.
                w_ras_we   = 1'b1;
                w_ras_widx = w_top_inc;
                w_top_nxt  = w_top_inc;
                w_cnt_nxt  = r_full ? r_count : r_count + c_cnt_one;
                w_pc_nxt   = pred_target_i & c_align_mask;
            end else begin
                w_pc_nxt = w_pc_seq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_ADDR;
            r_valid <= 1'b0;
            r_count <= '0;
            r_top   <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            // The first edge after reset only raises valid; pc stays put.
            r_valid <= 1'b1;
            r_pc    <= w_pc_nxt;
            r_count <= w_cnt_nxt;
            r_top   <= w_top_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == c_full_cnt);
        end
    end

    // Stack storage needs no reset: entries are only read when count > 0.
    always_ff @(posedge clk) begin
        if (w_ras_we) begin
            r_ras[w_ras_widx] <= w_ras_wdata;
        end
    end

    assign pc_o        = r_pc;
    assign pc_valid_o  = r_valid;
    assign ras_empty_o = r_empty;
    assign ras_full_o  = r_full;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Purpose  : Self-checking bench for pc_gen. A queue-based reference model
//            tracks pc / valid / RAS contents and is compared with the DUT on
//            every falling clock edge; directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam int unsigned ADDR_W    = 32;
    localparam logic [31:0] RESET_A   = 32'h0;
    localparam int unsigned RAS_DEPTH = 4;
    localparam logic [2:0]  PAUSE_LVL = 3'd1;
    localparam int unsigned C_EXT     = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trap_flag_i = 1'b0;
    logic [31:0] trap_addr_i = '0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic [2:0]  hold_flag_i = '0;
    logic        rvc_i = 1'b0;
    logic        pred_call_i = 1'b0;
    logic        pred_ret_i = 1'b0;
    logic [31:0] pred_target_i = '0;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        ras_empty_o;
    logic        ras_full_o;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_gen #(
        .ADDR_W        (ADDR_W),
        .RESET_ADDR    (RESET_A),
        .RAS_DEPTH     (RAS_DEPTH),
        .PAUSE_PC_LEVEL(PAUSE_LVL),
        .C_EXT         (C_EXT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trap_flag_i  (trap_flag_i),
        .trap_addr_i  (trap_addr_i),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .rvc_i        (rvc_i),
        .pred_call_i  (pred_call_i),
        .pred_ret_i   (pred_ret_i),
        .pred_target_i(pred_target_i),
        .pc_o         (pc_o),
        .pc_valid_o   (pc_valid_o),
        .ras_empty_o  (ras_empty_o),
        .ras_full_o   (ras_full_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_pc    = RESET_A;
    logic        m_valid = 1'b0;
    logic [31:0] m_ras[$];

    function automatic logic [31:0] align_a(input logic [31:0] a);
        return (C_EXT != 0) ? (a & 32'hFFFF_FFFE) : (a & 32'hFFFF_FFFC);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] st;
        logic [31:0] top;
        if (!rst_n) begin
            m_pc    = RESET_A;
            m_valid = 1'b0;
            m_ras.delete();
        end else if (!m_valid) begin
            m_valid = 1'b1;
        end else begin
            st = ((C_EXT != 0) && rvc_i) ? 32'd2 : 32'd4;
            if (trap_flag_i) begin
                m_pc = align_a(trap_addr_i);
                m_ras.delete();
            end else if (jump_flag_i) begin
                m_pc = align_a(jump_addr_i);
            end else if (hold_flag_i >= PAUSE_LVL) begin
                m_pc = m_pc;
            end else if (pred_ret_i && m_ras.size() > 0) begin
                top = m_ras[m_ras.size()-1];
                if (pred_call_i) m_ras[m_ras.size()-1] = m_pc + st;
                else void'(m_ras.pop_back());
                m_pc = top;
            end else if (pred_call_i) begin
                if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
                m_ras.push_back(m_pc + st);
                m_pc = align_a(pred_target_i);
            end else begin
                m_pc = m_pc + st;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        logic e_empty, e_full;
        e_empty = (m_ras.size() == 0);
        e_full  = (m_ras.size() == RAS_DEPTH);
        n_cmp++;
        if (pc_o !== m_pc || pc_valid_o !== m_valid ||
            ras_empty_o !== e_empty || ras_full_o !== e_full) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t: got pc=%h valid=%b empty=%b full=%b, required pc=%h valid=%b empty=%b full=%b",
                     $time, pc_o, pc_valid_o, ras_empty_o, ras_full_o, m_pc, m_valid, e_empty, e_full);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        trap_flag_i = 1'b0; jump_flag_i = 1'b0; hold_flag_i = '0;
        rvc_i = 1'b0; pred_call_i = 1'b0; pred_ret_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) cyc();
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_valid", {31'b0, pc_valid_o}, 32'h0);
        chk("rst_empty", {31'b0, ras_empty_o}, 32'h1);
        chk("rst_full", {31'b0, ras_full_o}, 32'h0);

        // Start-up sequence
        rst_n = 1'b1;
        cyc(); chk("start_pc", pc_o, 32'h0); chk("start_valid", {31'b0, pc_valid_o}, 32'h1);
        cyc(); chk("seq_4", pc_o, 32'h4);
        cyc(); chk("seq_8", pc_o, 32'h8);
        cyc(); chk("seq_c", pc_o, 32'hC);

        // Asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc_o, 32'h0);
        chk("async_rst_valid", {31'b0, pc_valid_o}, 32'h0);
        #1 rst_n = 1'b1;
        cyc(); chk("restart_pc", pc_o, 32'h0); chk("restart_valid", {31'b0, pc_valid_o}, 32'h1);

        // Compressed step pattern
        rvc_i = 1'b1; cyc(); chk("rvc_2", pc_o, 32'h2);
        rvc_i = 1'b0; cyc(); chk("rvc_6", pc_o, 32'h6);
        rvc_i = 1'b1; cyc(); chk("rvc_8", pc_o, 32'h8);
        rvc_i = 1'b0;

        // Wrap-around
        jump_flag_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
        cyc(); chk("jump_top", pc_o, 32'hFFFF_FFFC);
        jump_flag_i = 1'b0;
        cyc(); chk("wrap_0", pc_o, 32'h0);

        // Jump beats hold, then hold freezes and ignores calls
        hold_flag_i = 3'd1; jump_flag_i = 1'b1; jump_addr_i = 32'h103;
        cyc(); chk("jump_over_hold", pc_o, 32'h102);
        jump_flag_i = 1'b0; pred_call_i = 1'b1; pred_target_i = 32'h500;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("hold_pc", pc_o, 32'h102); chk("hold_empty", {31'b0, ras_empty_o}, 32'h1);
        end
        idle_inputs();

        // Nested calls and returns
        jump_flag_i = 1'b1; jump_addr_i = 32'h10; cyc(); jump_flag_i = 1'b0;
        pred_call_i = 1'b1; pred_target_i = 32'h100; cyc(); chk("call1", pc_o, 32'h100);
        pred_call_i = 1'b0; cyc(); chk("after_call1", pc_o, 32'h104);
        pred_call_i = 1'b1; pred_target_i = 32'h200; cyc(); chk("call2", pc_o, 32'h200);
        pred_call_i = 1'b0; pred_ret_i = 1'b1;
        cyc(); chk("ret1", pc_o, 32'h108);
        cyc(); chk("ret2", pc_o, 32'h14); chk("model_ret2", m_pc, 32'h14);
        chk("nest_empty", {31'b0, ras_empty_o}, 32'h1);
        idle_inputs();

        // Overflow: 5 calls then 5 returns
        jump_flag_i = 1'b1; jump_addr_i = 32'h1000; cyc(); jump_flag_i = 1'b0;
        pred_call_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pred_target_i = 32'h2000 + 32'(i) * 32'h100;
            cyc(); chk("ovf_call", pc_o, pred_target_i);
            if (i == 3) chk("full_after_4", {31'b0, ras_full_o}, 32'h1);
        end
        pred_call_i = 1'b0; pred_ret_i = 1'b1;
        cyc(); chk("ovf_ret1", pc_o, 32'h2304);
        cyc(); chk("ovf_ret2", pc_o, 32'h2204);
        cyc(); chk("ovf_ret3", pc_o, 32'h2104);
        cyc(); chk("ovf_ret4", pc_o, 32'h2004); chk("ovf_empty", {31'b0, ras_empty_o}, 32'h1);
        cyc(); chk("ovf_ret5_seq", pc_o, 32'h2008); chk("model_ret5", m_pc, 32'h2008);
        idle_inputs();

        // Trap outranks jump and ret, and flushes the RAS
        pred_call_i = 1'b1; pred_target_i = 32'h40;
        repeat (3) cyc();
        pred_call_i = 1'b0;
        chk("three_not_empty", {31'b0, ras_empty_o}, 32'h0);
        trap_flag_i = 1'b1; trap_addr_i = 32'h3001; jump_flag_i = 1'b1;
        jump_addr_i = 32'h4000; pred_ret_i = 1'b1;
        cyc(); chk("trap_pc", pc_o, 32'h3000); chk("trap_empty", {31'b0, ras_empty_o}, 32'h1);
        idle_inputs();

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            trap_flag_i   = ($urandom_range(0, 39) == 0);
            trap_addr_i   = $urandom;
            jump_flag_i   = ($urandom_range(0, 9) == 0);
            jump_addr_i   = $urandom;
            hold_flag_i   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            rvc_i         = 1'($urandom_range(0, 1));
            pred_call_i   = ($urandom_range(0, 3) == 0);
            pred_ret_i    = ($urandom_range(0, 3) == 0);
            pred_target_i = $urandom;
            cyc();
        end
        idle_inputs();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
